// File: rtl/priority_encoder_pkg.sv
// priority_encoder_pkg: shared widths and types for the priority encoder
// Provides the default request width and the matching vector/index typedefs.
package priority_encoder_pkg;
    localparam int NUM_WIRE_DEFAULT = 16;
    localparam int ENCODE_W = $clog2(NUM_WIRE_DEFAULT);
    typedef logic [NUM_WIRE_DEFAULT-1:0] n_wire_t;
    typedef logic [ENCODE_W-1:0] n_encode_t;
endpackage

// File: rtl/priority_encoder_node.sv
// priority_encoder_node: merges two child (valid, index) pairs of the encoder tree
// Ports: lo_valid/lo_index - lower-numbered child; hi_valid/hi_index - upper child;
//        valid/index - merged result, index bit LVL marks a win by the upper child.
// An invalid child always carries index 0, so an invalid node also yields 0.
module priority_encoder_node #(
    parameter int W   = 4,
    parameter int LVL = 0
) (
    input  logic         lo_valid,
    input  logic [W-1:0] lo_index,
    input  logic         hi_valid,
    input  logic [W-1:0] hi_index,
    output logic         valid,
    output logic [W-1:0] index
);
    always_comb begin
        valid = lo_valid | hi_valid;
        index = lo_valid ? lo_index : hi_index | (W'(hi_valid) << LVL);
    end
endmodule

// File: rtl/priority_encoder.sv
// priority_encoder: index of the lowest set bit of wire_in, combinational and registered
// Ports: clk_i - clock for the output registers; arst_ni - async active-low reset
//        of the registers; wire_in - request vector (bit 0 highest priority);
//        index_o/valid_o - combinational result; index_q_o/valid_q_o - registered copy.
module priority_encoder
    import priority_encoder_pkg::*;
#(
    parameter int NUM_WIRE = NUM_WIRE_DEFAULT
) (
    input  logic                        clk_i,
    input  logic                        arst_ni,
    input  logic [NUM_WIRE-1:0]         wire_in,
    output logic [$clog2(NUM_WIRE)-1:0] index_o,
    output logic                        valid_o,
    output logic [$clog2(NUM_WIRE)-1:0] index_q_o,
    output logic                        valid_q_o
);
    localparam int W = $clog2(NUM_WIRE);
    localparam int P = 1 << W;
    localparam int N = 2 * P - 1;
    // Heap-ordered tree: node n has children 2n+1 (lower bits) and 2n+2; leaves start at P-1.
    logic [P-1:0] wire_pad;
    logic         node_valid [N];
    logic [W-1:0] node_index [N];
    assign wire_pad = P'(wire_in);
    genvar k, d, j;
    for (k = 0; k < P; k++) begin : g_leaf
        assign node_valid[P-1+k] = wire_pad[k];
        assign node_index[P-1+k] = '0;
    end
    for (d = 0; d < W; d++) begin : g_lvl
        for (j = 0; j < (1 << d); j++) begin : g_node
            localparam int n = (1 << d) - 1 + j;
            priority_encoder_node #(.W(W), .LVL(W - 1 - d)) u_node (
                .lo_valid (node_valid[2*n+1]),
                .lo_index (node_index[2*n+1]),
                .hi_valid (node_valid[2*n+2]),
                .hi_index (node_index[2*n+2]),
                .valid    (node_valid[n]),
                .index    (node_index[n])
            );
        end
    end
    assign index_o = node_index[0];
    assign valid_o = node_valid[0];
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            index_q_o <= '0;
            valid_q_o <= 1'b0;
        end else begin
            index_q_o <= index_o;
            valid_q_o <= valid_o;
        end
    end
endmodule

// File: tb/tb_priority_encoder.sv
// tb_priority_encoder: checks 16-wide and 5-wide encoders against a lowest-set-bit model
module tb_priority_encoder;
    import priority_encoder_pkg::*;
    logic      clk_i = 1'b0;
    logic      arst_ni = 1'b0;
    n_wire_t   wire_in;
    n_encode_t index_o, index_q_o;
    logic      valid_o, valid_q_o;
    logic [4:0] w5;
    logic [2:0] i5, iq5;
    logic       v5, vq5;
    int vectors = 0;
    int miscompares = 0;
    typedef struct {
        logic [15:0] w;
        int          idx;
        logic        v;
    } vec_t;
    typedef struct {
        logic [4:0] w;
        int         idx;
        logic       v;
    } vec5_t;
    vec_t  tbl [22];
    vec5_t tbl5 [3];
    priority_encoder #(.NUM_WIRE(16)) dut (
        .clk_i(clk_i), .arst_ni(arst_ni), .wire_in(wire_in),
        .index_o(index_o), .valid_o(valid_o), .index_q_o(index_q_o), .valid_q_o(valid_q_o)
    );
    priority_encoder #(.NUM_WIRE(5)) dut5 (
        .clk_i(clk_i), .arst_ni(arst_ni), .wire_in(w5),
        .index_o(i5), .valid_o(v5), .index_q_o(iq5), .valid_q_o(vq5)
    );
    always #5 clk_i = ~clk_i;
    // Isolate the lowest set bit arithmetically, then take its log2.
    function automatic int lsb_idx(logic [31:0] x);
        logic [31:0] iso;
        iso = x & (~x + 32'd1);
        return (x == 0) ? 0 : $clog2(iso);
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask
    initial begin
        int e_idx, e5;
        logic e_v, e5v;
        tbl[0] = '{16'h0000, 0, 1'b0};
        tbl[1] = '{16'h0001, 0, 1'b1};
        tbl[2] = '{16'h8000, 15, 1'b1};
        tbl[3] = '{16'hFFFF, 0, 1'b1};
        tbl[4] = '{16'hA0F0, 4, 1'b1};
        tbl[5] = '{16'h8400, 10, 1'b1};
        for (int k = 0; k < 16; k++) tbl[6+k] = '{16'(1) << k, k, 1'b1};
        tbl5[0] = '{5'b10000, 4, 1'b1};
        tbl5[1] = '{5'b00000, 0, 1'b0};
        tbl5[2] = '{5'b11010, 1, 1'b1};
        wire_in = 16'h1234;
        w5 = 5'b00110;
        #1;
        chk("reset index_q", 32'(index_q_o), 0);
        chk("reset valid_q", 32'(valid_q_o), 0);
        chk("reset comb index", 32'(index_o), 2);
        @(negedge clk_i);
        arst_ni = 1'b1;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk_i);
            wire_in = tbl[i].w;
            #1;
            chk($sformatf("table index w=%h", tbl[i].w), 32'(index_o), 32'(tbl[i].idx));
            chk($sformatf("table valid w=%h", tbl[i].w), 32'(valid_o), 32'(tbl[i].v));
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            w5 = tbl5[i].w;
            #1;
            chk($sformatf("nw5 index w=%b", tbl5[i].w), 32'(i5), 32'(tbl5[i].idx));
            chk($sformatf("nw5 valid w=%b", tbl5[i].w), 32'(v5), 32'(tbl5[i].v));
        end
        @(negedge clk_i);
        wire_in = 16'h0100;
        @(posedge clk_i);
        #1;
        chk("reg index 0100", 32'(index_q_o), 8);
        chk("reg valid 0100", 32'(valid_q_o), 1);
        @(negedge clk_i);
        wire_in = 16'h0000;
        @(posedge clk_i);
        #1;
        chk("reg index 0000", 32'(index_q_o), 0);
        chk("reg valid 0000", 32'(valid_q_o), 0);
        @(negedge clk_i);
        wire_in = 16'h0040;
        @(posedge clk_i);
        #1;
        chk("pre-reset index_q", 32'(index_q_o), 6);
        #2;
        arst_ni = 1'b0;
        #1;
        chk("mid reset index_q", 32'(index_q_o), 0);
        chk("mid reset valid_q", 32'(valid_q_o), 0);
        chk("mid reset index", 32'(index_o), 6);
        chk("mid reset valid", 32'(valid_o), 1);
        @(posedge clk_i);
        #1;
        chk("held reset index_q", 32'(index_q_o), 0);
        @(negedge clk_i);
        arst_ni = 1'b1;
        #1;
        chk("released index_q", 32'(index_q_o), 0);
        @(posedge clk_i);
        #1;
        chk("after release index_q", 32'(index_q_o), 6);
        chk("after release valid_q", 32'(valid_q_o), 1);
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk_i);
            wire_in = 16'($urandom);
            if ($urandom_range(0, 7) == 0) wire_in = 16'(1) << $urandom_range(0, 15);
            w5 = 5'($urandom_range(0, 31));
            e_idx = lsb_idx(32'(wire_in));
            e_v = wire_in != 0;
            e5 = lsb_idx(32'(w5));
            e5v = w5 != 0;
            #1;
            chk($sformatf("rand index w=%h", wire_in), 32'(index_o), 32'(e_idx));
            chk($sformatf("rand valid w=%h", wire_in), 32'(valid_o), 32'(e_v));
            chk($sformatf("rand nw5 index w=%b", w5), 32'(i5), 32'(e5));
            chk($sformatf("rand nw5 valid w=%b", w5), 32'(v5), 32'(e5v));
            @(posedge clk_i);
            #1;
            chk($sformatf("rand index_q w=%h", wire_in), 32'(index_q_o), 32'(e_idx));
            chk($sformatf("rand valid_q w=%h", wire_in), 32'(valid_q_o), 32'(e_v));
            chk($sformatf("rand nw5 index_q w=%b", w5), 32'(iq5), 32'(e5));
            chk($sformatf("rand nw5 valid_q w=%b", w5), 32'(vq5), 32'(e5v));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
